// File: rtl/mips_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them
// into instruction memory, then holds the MIPS core in reset briefly before releasing it.
module mips_boot_loader #(
  parameter int WORDS       = 256,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  len,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int         HCW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [8:0] WORDS_L = 9'(WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, HOLD, RUN} state_t;

  state_t           state;
  logic [8:0]       len_q;
  logic [8:0]       word_cnt;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic [HCW-1:0]   hold_cnt;
  logic             len_ok;

  assign len_ok = (len != 9'd0) && (len <= WORDS_L);

  // Outputs are registered alongside the state, so each branch sets the outputs
  // that belong to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len_q      <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      hold_cnt   <= '0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err     <= 1'b0;
      imem_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            if (len_ok) begin
              state     <= LOAD;
              len_q     <= len;
              word_cnt  <= '0;
              byte_cnt  <= '0;
              s_ready   <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
              cpu_reset <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= s_data;
              2'd1: word_buf[15:8]  <= s_data;
              2'd2: word_buf[23:16] <= s_data;
              default: begin
                // Fourth byte goes straight into the write data; no extra buffer stage.
                state      <= WRITE;
                s_ready    <= 1'b0;
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt[7:0];
                imem_wdata <= {s_data, word_buf};
              end
            endcase
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + 9'd1;
          if (word_cnt + 9'd1 == len_q) begin
            state    <= HOLD;
            hold_cnt <= HCW'(HOLD_CYCLES - 1);
          end else begin
            state   <= LOAD;
            s_ready <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          s_ready   <= 1'b0;
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized self-checking bench for mips_boot_loader against a byte/word stream model.
module tb_mips_boot_loader;
  localparam int WORDS       = 256;
  localparam int HOLD_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  len = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, imem_we, cpu_reset, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  int checks = 0;
  int errors = 0;
  byte unsigned stim_q[$];

  mips_boot_loader #(.WORDS(WORDS), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Starts a load of n words from stim_q and follows it into RUN.
  // vmode: 0 = always valid, 1 = valid every other cycle, 2 = random valid.
  task automatic run_load(input int n, input int vmode, input bit noisy, input string tag);
    int sent = 0, cyc = 0, wr = 0, k = 0;
    int total = n * 4;
    int budget = n * 4 * 12 + 50;
    bit v, rdy, took, exp_we;
    bit exp_rdy = 1'b1;
    logic [31:0] exp_word;
    @(negedge clk);
    start = 1'b1;
    len = 9'(n);
    @(posedge clk); #1;
    checks++;
    if ({busy, s_ready, cpu_reset, done, err} !== 5'b11100) begin
      errors++;
      $display("FAIL %s start_accept: busy/rdy/cpu_rst/done/err=%b expected 11100", tag,
               {busy, s_ready, cpu_reset, done, err});
    end
    while (sent < total && cyc < budget) begin
      @(negedge clk);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      len = 9'($urandom_range(0, 300));
      rdy = s_ready;
      checks++;
      if (rdy !== exp_rdy) begin
        errors++;
        $display("FAIL %s s_ready: got %b expected %b (byte %0d)", tag, rdy, exp_rdy, sent);
      end
      case (vmode)
        0: v = 1'b1;
        1: v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data = stim_q[sent];
      @(posedge clk); #1;
      cyc++;
      took = v && rdy;
      if (took) sent++;
      exp_we = took && (sent % 4 == 0);
      exp_rdy = !exp_we;
      checks++;
      if (imem_we !== exp_we) begin
        errors++;
        $display("FAIL %s imem_we: got %b expected %b (byte %0d)", tag, imem_we, exp_we, sent);
      end
      if (exp_we) begin
        exp_word = stim_q[sent-4] + stim_q[sent-3] * 256 + stim_q[sent-2] * 65536
                   + stim_q[sent-1] * 16777216;
        checks++;
        if (imem_addr !== 8'(wr) || imem_wdata !== exp_word) begin
          errors++;
          $display("FAIL %s write: addr %0d data %h expected addr %0d data %h", tag,
                   imem_addr, imem_wdata, wr, exp_word);
        end
        wr++;
      end
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL %s err_in_load: got %b expected 0", tag, err);
      end
    end
    if (sent < total) begin
      checks++; errors++;
      $display("FAIL %s timeout: sent %0d bytes expected %0d", tag, sent, total);
    end
    do begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 8'($urandom);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      k++;
      checks++;
      if (imem_we !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold_outputs: we/err/rdy=%b%b%b expected 000", tag, imem_we, err, s_ready);
      end
    end while (cpu_reset !== 1'b0 && k < 20);
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (k != HOLD_CYCLES + 1 || wr != n) begin
      errors++;
      $display("FAIL %s release: cpu_reset fell after %0d edges with %0d writes, expected %0d and %0d",
               tag, k, wr, HOLD_CYCLES + 1, n);
    end
    checks++;
    if ({cpu_reset, busy, done} !== 3'b001) begin
      errors++;
      $display("FAIL %s run_state: cpu_rst/busy/done=%b expected 001", tag, {cpu_reset, busy, done});
    end
  endtask

  task automatic test_reset();
    logic [45:0] got;
    reset = 1'b0;
    #13;
    got = {cpu_reset, s_ready, imem_we, imem_addr, imem_wdata, busy, done, err};
    checks++;
    if (got !== {1'b1, 45'd0}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", got, {1'b1, 45'd0});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cpu_reset, busy, done, s_ready, imem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 10000",
               {cpu_reset, busy, done, s_ready, imem_we});
    end
  endtask

  task automatic test_illegal_len(input bit in_run);
    logic [4:0] exp_st;
    int bad[3];
    exp_st = in_run ? 5'b00100 : 5'b10000;
    bad[0] = 0;
    bad[1] = 257;
    bad[2] = $urandom_range(257, 511);
    foreach (bad[i]) begin
      @(negedge clk);
      start = 1'b1;
      len = 9'(bad[i]);
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b1 || {cpu_reset, busy, done, s_ready, imem_we} !== exp_st) begin
        errors++;
        $display("FAIL illegal_len_%0d: err %b state %b expected err 1 state %b",
                 bad[i], err, {cpu_reset, busy, done, s_ready, imem_we}, exp_st);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || {cpu_reset, busy, done, s_ready, imem_we} !== exp_st) begin
        errors++;
        $display("FAIL illegal_len_pulse_%0d: err %b state %b expected err 0 state %b",
                 bad[i], err, {cpu_reset, busy, done, s_ready, imem_we}, exp_st);
      end
    end
  endtask

  task automatic test_two_words();
    stim_q = '{8'h20, 8'h10, 8'h08, 8'h8C, 8'h00, 8'h00, 8'h00, 8'h08};
    run_load(2, 0, 1'b0, "two_words");
  endtask

  task automatic test_backpressure();
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    run_load(1, 1, 1'b0, "backpressure");
  endtask

  task automatic test_reload_from_run();
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    run_load(1, 2, 1'b1, "reload_run");
  endtask

  task automatic test_full_depth();
    stim_q.delete();
    for (int i = 0; i < WORDS * 4; i++) stim_q.push_back(8'(i));
    run_load(WORDS, 2, 1'b1, "full_depth");
  endtask

  task automatic test_reset_mid_load();
    logic [45:0] got;
    int acc = 0, cyc = 0;
    @(negedge clk);
    start = 1'b1;
    len = 9'd4;
    @(negedge clk);
    start = 1'b0;
    while (acc < 6 && cyc < 40) begin
      s_valid = 1'b1;
      s_data = 8'($urandom);
      if (s_ready === 1'b1) acc++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    got = {cpu_reset, s_ready, imem_we, imem_addr, imem_wdata, busy, done, err};
    checks++;
    if (got !== {1'b1, 45'd0} || acc != 6) begin
      errors++;
      $display("FAIL mid_load_reset: got %h after %0d bytes expected %h after 6", got, acc, {1'b1, 45'd0});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({imem_we, s_ready, cpu_reset, busy} !== 4'b0010) begin
        errors++;
        $display("FAIL post_reset_idle: we/rdy/cpu_rst/busy=%b expected 0010",
                 {imem_we, s_ready, cpu_reset, busy});
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    run_load(1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 8);
      stim_q.delete();
      for (int i = 0; i < n * 4; i++) stim_q.push_back(8'($urandom));
      run_load(n, $urandom_range(0, 2), 1'b1, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_illegal_len(1'b0);
    test_two_words();
    test_illegal_len(1'b1);
    test_reload_from_run();
    test_backpressure();
    test_full_depth();
    test_reset_mid_load();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
